// File: rtl/burst_seq_ctrl.sv
// +---------------------------------------------------------------------------+
// | burst_seq_ctrl: start -> ready after READY_LAT, BURST_LEN stallable beats  |
// | of seed+n, then burst_end. Optional: BURST_SEQ_CTRL_TIMEOUT_EN.            |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module burst_seq_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int READY_LAT = 3,
  parameter int STALL_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              burst_end,
  output logic              busy,
  output logic              error
);

  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  localparam int LCNT_W = $clog2(READY_LAT + 1);
  localparam logic [LCNT_W-1:0] LAT_LAST  = LCNT_W'(READY_LAT - 1);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RDY  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;

  if (BURST_LEN < 1 || READY_LAT < 1 || STALL_MAX < 1) begin : g_param_check
    $error("burst_seq_ctrl: BURST_LEN, READY_LAT and STALL_MAX must be >= 1");
  end

  logic [2:0]        state_q, state_d;
  logic [LCNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              error_q, error_d;
  logic              w_accept;
  logic              w_timeout;

  assign w_accept = (state_q == S_DATA) && !stall;

`ifdef BURST_SEQ_CTRL_TIMEOUT_EN
  localparam int SCNT_W = $clog2(STALL_MAX + 1);
  localparam logic [SCNT_W-1:0] STALL_LAST = SCNT_W'(STALL_MAX - 1);

  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts consecutive stalled edges; any accepted beat or leaving DATA clears it.
  always_comb begin
    stall_cnt_d = '0;
    if (state_q == S_DATA && stall) begin
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign w_timeout = (state_q == S_DATA) && stall && (stall_cnt_q == STALL_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (READY_LAT == 1) ? S_RDY : S_WAIT;
      S_WAIT: if (lat_cnt_q == LAT_LAST) state_d = S_RDY;
      S_RDY:  state_d = S_DATA;
      S_DATA: begin
        if (w_accept && beat_cnt_q == BEAT_LAST) begin
          state_d = S_END;
        end else if (w_timeout) begin
          state_d = S_END;
        end
      end
      S_END:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready      = (state_q == S_RDY);
    data_valid = (state_q == S_DATA);
    burst_end  = (state_q == S_END);
    busy       = (state_q != S_IDLE);
    data_out   = dout_q;
    error      = error_q;
  end

  // dout_q tracks seed + beat_cnt but freezes on the final beat so END and IDLE show it.
  always_comb begin
    lat_cnt_d  = lat_cnt_q;
    beat_cnt_d = beat_cnt_q;
    seed_d     = seed_q;
    dout_d     = dout_q;
    error_d    = (start && state_q != S_IDLE) || w_timeout;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d    = data_in;
          lat_cnt_d = LCNT_W'(1);
        end
      end
      S_WAIT: lat_cnt_d = lat_cnt_q + LCNT_W'(1);
      S_RDY: begin
        beat_cnt_d = '0;
        dout_d     = seed_q;
      end
      S_DATA: begin
        if (w_accept) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (beat_cnt_q != BEAT_LAST) begin
            dout_d = dout_q + DATA_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
      seed_q     <= '0;
      dout_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      seed_q     <= seed_d;
      dout_q     <= dout_d;
      error_q    <= error_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/burst_seq_ctrl.md
Name: burst_seq_ctrl

Overview:
Parametrised burst sequencer. A start pulse triggers a ready pulse after a fixed latency, then BURST_LEN data beats under a stall handshake, then a single burst_end pulse. Next-generation handshake DUT for the assertion labs: it generalises the fixed start→ready, burst_start→4×data_valid→burst_end and data-stable-while-valid behaviours to configurable latency, length and width, and adds a stall handshake.

Parameters:
DATA_W, 8, width of data_in/data_out
BURST_LEN, 4, beats per burst (≥1)
READY_LAT, 3, cycles from start sample to ready (≥1)
STALL_MAX, 8, stall timeout in cycles (used only with BURST_SEQ_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  burst request, sampled on clk in IDLE only
stall  in  1  consumer back-pressure; a beat is accepted when data_valid && !stall
data_in  in  DATA_W  burst seed value, captured when start is accepted
ready  out  1  one-cycle pulse READY_LAT cycles after start is accepted
data_valid  out  1  beat presented on data_out
data_out  out  DATA_W  beat payload
burst_end  out  1  one-cycle pulse after the last beat is accepted
busy  out  1  high in every state except IDLE
error  out  1  one-cycle pulse: start high while busy (or timeout, see below)

Behaviour:
- Reset (async, asserting rst): all outputs 0, state IDLE, counters 0. This applies mid-burst; no burst_end is issued for an aborted burst. First start is accepted on the first rising edge after rst deasserts.
- States: IDLE, WAIT, RDY, DATA, END.
- IDLE: start=1 at edge → capture data_in into seed, lat_cnt=1, go WAIT (or RDY if READY_LAT==1).
- WAIT: lat_cnt increments each edge; at lat_cnt==READY_LAT-1, go RDY.
  - Net timing: start sampled at edge N → ready=1 for exactly the cycle after edge N+READY_LAT-1, i.e. $rose-style `start |-> ##READY_LAT ready`.
- RDY: ready=1 for one cycle, then go DATA with beat_cnt=0.
- DATA:
  - data_valid=1 continuously.
  - data_out = seed + beat_cnt, modulo 2^DATA_W (wraps, no carry out).
  - On an edge with stall=0: beat accepted, beat_cnt++.
  - On an edge with stall=1: data_out and beat_cnt hold; data_out must be stable for the entire data_valid-high, stall-high interval.
  - When beat BURST_LEN-1 is accepted → END; data_valid drops the next cycle.
  - beat_cnt width: $clog2(BURST_LEN+1).
- END: burst_end=1 for one cycle, data_valid=0, data_out holds its last value; go IDLE. busy=1 in END.
- start while busy (WAIT/RDY/DATA/END): ignored; error=1 the following cycle for one cycle. Level-held start raises error every cycle it is high while busy.
- start held high continuously: accepted once in IDLE; the next burst starts on the first IDLE edge where start is still high (back-to-back with a 1-cycle IDLE gap).
- data_out outside DATA/END: 0 after reset; otherwise holds the last burst value.
- ready, data_valid and burst_end are mutually exclusive in every cycle.

Optional Feature:
BURST_SEQ_CTRL_TIMEOUT_EN
- Defined: a stall_cnt counts consecutive stalled cycles in DATA and clears on beat acceptance. When stall_cnt reaches STALL_MAX, the burst aborts: error=1 for one cycle, data_valid drops, and the FSM goes to END (burst_end still pulses once), then IDLE.
- Not defined: stall may be held indefinitely; no stall_cnt logic is present and STALL_MAX is unused.

Test Plan:
- Default params, data_in=8'h10, pulse start 1 cycle, stall=0 → ready exactly 3 cycles later; data_out 10,11,12,13 on 4 consecutive data_valid cycles; burst_end the next cycle; busy low after that.
- stall=1 for 2 cycles during beat 2 → data_out stays 8'h11 for 3 cycles with data_valid high; exactly 4 accepted beats; burst_end one cycle after the 4th acceptance.
- DATA_W=3, data_in=3'b110, BURST_LEN=4 → data_out 6,7,0,1 (wrap).
- start pulsed again during DATA → error=1 for one cycle, beat sequence unaffected, no second ready.
- Assert rst in beat 2 → all outputs 0 immediately (asynchronously); no burst_end; a new start after release gives ready READY_LAT cycles later.
- With BURST_SEQ_CTRL_TIMEOUT_EN and STALL_MAX=8, stall held for 8 cycles in DATA → error pulse, data_valid drops, burst_end pulses once, FSM returns to IDLE.
